// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
//   state_e      : FSM state encoding (2 bits)
//   DEF_PATTERN  : default transmitted pattern, MSB sent first
//   idx_width()  : width of the bit index register for a given pattern length
package seq_gen_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam logic [3:0] DEF_PATTERN = 4'b1010;

   // Never returns 0, so a 1-bit pattern would still get a legal index vector.
   function automatic int unsigned idx_width(input int unsigned pat_w);
      return (pat_w > 1) ? $clog2(pat_w) : 1;
   endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter. Sends PATTERN MSB first, rep_cnt times, with gap_len
// zero bits between copies. Moore FSM: every output decodes from registered state.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   transfer request, sampled only in idle
//   rep_cnt    in   number of pattern copies, latched with start
//   gap_len    in   zero bits between copies, latched with start
//   abort      in   drop the rest of the transfer, no done pulse
//   bit_out    out  serial data
//   bit_valid  out  bit_out carries a pattern or gap bit
//   pat_end    out  last bit of a pattern copy is on bit_out
//   busy       out  transfer in progress (send or gap)
//   done       out  one-cycle pulse after normal completion
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned          PAT_W   = 4,
   parameter logic [PAT_W-1:0]     PATTERN = DEF_PATTERN,
   parameter int unsigned          CNT_W   = 8,
   parameter int unsigned          GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] rep_cnt,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             abort,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             pat_end,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      IDX_W   = idx_width(PAT_W);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PAT_W - 1);
   localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [GAP_W-1:0] GapOne  = GAP_W'(1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0] reps_left_q, reps_left_d;
   logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_idx_q   <= '0;
         reps_left_q <= '0;
         gap_reg_q   <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         reps_left_q <= reps_left_d;
         gap_reg_q   <= gap_reg_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   // Next-state and counter updates. Counters only decrement from nonzero values.
   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      reps_left_d = reps_left_q;
      gap_reg_d   = gap_reg_q;
      gap_cnt_d   = gap_cnt_q;

      case (state_q)
         StIdle: begin
            // abort in idle only serves to veto a simultaneous start
            if (start && !abort) begin
               if (rep_cnt != '0) begin
                  reps_left_d = rep_cnt;
                  gap_reg_d   = gap_len;
                  bit_idx_d   = LastIdx;
                  state_d     = StSend;
               end else begin
                  state_d = StDone;
               end
            end
         end

         StSend: begin
            if (abort) begin
               state_d = StIdle;
            end else if (bit_idx_q != '0) begin
               bit_idx_d = bit_idx_q - IdxOne;
            end else if (reps_left_q == CntOne) begin
               state_d = StDone;
            end else begin
               reps_left_d = reps_left_q - CntOne;
               if (gap_reg_q == '0) begin
                  // back-to-back copy, no gap state visited
                  bit_idx_d = LastIdx;
               end else begin
                  gap_cnt_d = gap_reg_q;
                  state_d   = StGap;
               end
            end
         end

         StGap: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - GapOne;
               if (gap_cnt_q == GapOne) begin
                  bit_idx_d = LastIdx;
                  state_d   = StSend;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Moore output decode.
   always_comb begin
      bit_out   = 1'b0;
      bit_valid = 1'b0;
      pat_end   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         StSend: begin
            bit_out   = PATTERN[bit_idx_q];
            bit_valid = 1'b1;
            busy      = 1'b1;
            pat_end   = (bit_idx_q == '0);
         end
         StGap: begin
            bit_valid = 1'b1;
            busy      = 1'b1;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

   localparam int unsigned   PAT_W = 4;
   localparam int unsigned   CNT_W = 8;
   localparam int unsigned   GAP_W = 4;
   localparam logic [3:0]    PAT   = 4'b1010;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_len;
   logic             abort;
   logic             bit_out;
   logic             bit_valid;
   logic             pat_end;
   logic             busy;
   logic             done;

   seq_pattern_gen #(
      .PAT_W   (PAT_W),
      .PATTERN (PAT),
      .CNT_W   (CNT_W),
      .GAP_W   (GAP_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rep_cnt   (rep_cnt),
      .gap_len   (gap_len),
      .abort     (abort),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .pat_end   (pat_end),
      .busy      (busy),
      .done      (done)
   );

   // Expected output vector {bit_valid, bit_out, pat_end, busy, done} for a given cycle.
   typedef struct {
      int         cyc;
      logic [4:0] v;
   } ev_t;

   ev_t q[$];
   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle the outputs must match the due scoreboard entry, else be all zero.
   always @(negedge clk) begin
      logic [4:0] act;
      logic [4:0] exp;
      act = {bit_valid, bit_out, pat_end, busy, done};
      exp = '0;
      if (q.size() != 0 && q[0].cyc == cyc) begin
         exp = q[0].v;
         void'(q.pop_front());
      end
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL outputs cyc=%0d got {valid,bit,pat_end,busy,done}=%b want %b",
                  cyc, act, exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference model: the transmitted stream is the pattern copies joined by gap_len zeros,
   // one entry per cycle starting the cycle after start is sampled, then a done cycle.
   function automatic void expect_run(input int k, input int rep, input int gap);
      int         t;
      logic [3:0] pat;
      pat = PAT;
      t   = k + 1;
      for (int r = 0; r < rep; r++) begin
         for (int i = PAT_W - 1; i >= 0; i--) begin
            q.push_back('{t, {1'b1, pat[i], (i == 0), 1'b1, 1'b0}});
            t++;
         end
         if (r < rep - 1) begin
            for (int g = 0; g < gap; g++) begin
               q.push_back('{t, 5'b10010});
               t++;
            end
         end
      end
      q.push_back('{t, 5'b00001});
   endfunction

   function automatic void drop_from(input int c);
      while (q.size() != 0 && q[q.size()-1].cyc >= c) void'(q.pop_back());
   endfunction

   // Issue start now (caller is just past a rising edge), then wait for the stream to drain.
   task automatic run_now(input int rep, input int gap, input bit noise);
      int n;
      int len;
      start   = 1'b1;
      rep_cnt = CNT_W'(rep);
      gap_len = GAP_W'(gap);
      expect_run(cyc, rep, gap);
      step();
      start   = 1'b0;
      rep_cnt = CNT_W'($urandom);
      gap_len = GAP_W'($urandom);
      len = rep * PAT_W + ((rep > 0) ? (rep - 1) * gap : 0) + 4;
      n = 0;
      while (q.size() != 0 && n < len + 10) begin
         // stray starts while the generator is not idle must be ignored
         start   = noise && ($urandom_range(0, 3) == 0);
         rep_cnt = CNT_W'($urandom);
         step();
         n++;
      end
      start = 1'b0;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout rep=%0d gap=%0d pending=%0d want 0", rep, gap, q.size());
         q.delete();
      end
   endtask

   task automatic run(input int rep, input int gap, input bit noise);
      step();
      run_now(rep, gap, noise);
   endtask

   initial begin
      int k;
      int g;
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      rep_cnt = '0;
      gap_len = '0;
      #1;
      checks++;
      if ({bit_valid, bit_out, pat_end, busy, done} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got %b want 00000",
                  {bit_valid, bit_out, pat_end, busy, done});
      end
      step();
      step();
      rst = 1'b0;

      // Directed cases
      run(1, 0, 1'b0);
      run(3, 2, 1'b0);
      run(2, 0, 1'b0);
      run(0, 5, 1'b0);
      run(2, 15, 1'b1);
      run(255, 1, 1'b1);

      // start together with abort in idle: nothing happens
      step();
      start   = 1'b1;
      abort   = 1'b1;
      rep_cnt = 8'd2;
      step();
      start = 1'b0;
      abort = 1'b0;
      repeat (6) step();

      // Abort in the first gap of a 3-copy run, then restart right away
      step();
      k = cyc;
      g = $urandom_range(1, 15);
      start   = 1'b1;
      rep_cnt = 8'd3;
      gap_len = GAP_W'(g);
      expect_run(k, 3, g);
      step();
      start = 1'b0;
      repeat (4) step();
      abort = 1'b1;
      drop_from(cyc + 1);
      step();
      abort = 1'b0;
      run_now($urandom_range(1, 4), $urandom_range(0, 15), 1'b0);

      // Asynchronous reset in the middle of a pattern
      step();
      start   = 1'b1;
      rep_cnt = 8'd2;
      gap_len = 4'd3;
      expect_run(cyc, 2, 3);
      step();
      start = 1'b0;
      step();
      step();
      #1;
      drop_from(cyc);
      rst = 1'b1;
      #1;
      checks++;
      if ({bit_valid, bit_out, pat_end, busy, done} !== 5'b0) begin
         failures++;
         $display("FAIL async_reset got %b want 00000",
                  {bit_valid, bit_out, pat_end, busy, done});
      end
      step();
      step();
      rst = 1'b0;
      run(2, 1, 1'b0);

      // Randomized runs
      repeat (25) run($urandom_range(0, 5), $urandom_range(0, 15), 1'($urandom_range(0, 1)));

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter: emits a fixed PAT_W-bit pattern (default 1010), MSB first, one bit per clk, repeated rep_cnt times with gap_len idle-0 bits between repetitions. It produces stimulus and link traffic for the team's serial sequence detectors. It is a Moore FSM, so all outputs decode from registered state and datapath registers. It has a start/busy/done handshake and an abort.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PATTERN, 4'b1010, pattern transmitted, bit PAT_W-1 first
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-pattern gap length

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
rep_cnt  in  CNT_W  number of pattern repetitions; latched with start
gap_len  in  GAP_W  idle-0 bits between repetitions; latched with start
abort  in  1  terminate transfer, highest priority after rst
bit_out  out  1  serial data
bit_valid  out  1  bit_out is part of the stream (pattern or gap bit)
pat_end  out  1  high while the last bit of each pattern copy is on bit_out
busy  out  1  high in SEND and GAP
done  out  1  one-cycle pulse after normal completion

Behaviour:
- Reset is asynchronous: state=IDLE, all counters 0, all outputs 0.
- States: IDLE, SEND, GAP, DONE. Package enum, 2-bit encoding.
- IDLE, outputs: all outputs 0.
  - start=1, rep_cnt!=0: latch rep_cnt into reps_left and gap_len into gap_reg; bit_idx=PAT_W-1; next state SEND.
  - start=1, rep_cnt==0: next state DONE. No bits are emitted.
- SEND, outputs: bit_out=PATTERN[bit_idx], bit_valid=1, busy=1, pat_end=(bit_idx==0). Transitions:
  - bit_idx!=0: bit_idx decrements.
  - bit_idx==0 and reps_left==1: next state DONE.
  - bit_idx==0, reps_left>1, gap_reg==0: reps_left decrements, bit_idx=PAT_W-1, stay in SEND (back-to-back copies).
  - bit_idx==0, reps_left>1, gap_reg!=0: reps_left decrements, gap_cnt=gap_reg, next state GAP.
- GAP, outputs: bit_out=0, bit_valid=1, busy=1. gap_cnt decrements. When gap_cnt==1: bit_idx=PAT_W-1, next state SEND.
- DONE, outputs: done=1, all other outputs 0. Next state IDLE unconditionally.
- Latency:
  - First pattern bit appears in the cycle after the edge that samples start.
  - busy lasts exactly rep_cnt*PAT_W + (rep_cnt-1)*gap_len cycles.
  - done follows the last bit with no bubble.
- start while not IDLE is ignored. A new start is accepted in IDLE the cycle after DONE.
- abort=1 in SEND, GAP or DONE: next state IDLE, no done pulse, and any remaining bits are dropped. The registered outputs are zero from the following cycle. abort in IDLE has no effect and overrides start.
- Widths:
  - reps_left is CNT_W bits, so rep_cnt max is 2^CNT_W-1.
  - gap_cnt is GAP_W bits.
  - bit_idx is $clog2(PAT_W) bits.
  - No wrap-around is possible, because counters only decrement from nonzero.
- Illegal state encoding (unreachable): next state IDLE, outputs 0.

Decomposition:
- Package seq_gen_pkg: state enum (IDLE, SEND, GAP, DONE); the constant DEF_PATTERN=4'b1010; a function for the bit_idx width.
- No sub-module is needed. Counters and FSM stay in one module, with a separate next-state block and state-register block.

Test Plan:
1. rep_cnt=1, gap_len=0, start pulse -> bit_out 1,0,1,0 with bit_valid=1 for 4 cycles; pat_end on the 4th bit; done pulse on cycle 5; busy high 4 cycles.
2. rep_cnt=3, gap_len=2 -> stream 1010 00 1010 00 1010, busy high 16 cycles, pat_end 3 pulses, 1 done pulse.
3. rep_cnt=2, gap_len=0 -> 10101010 back-to-back, busy 8 cycles, pat_end at bits 4 and 8.
4. rep_cnt=0, start -> no bit_valid, busy stays 0, done pulse the cycle after start.
5. Abort in GAP of a rep_cnt=3 run -> IDLE next cycle, no done pulse, outputs 0. A new start on the following cycle transmits correctly.
6. rst asserted asynchronously mid-SEND -> all outputs 0 immediately. start pulses during busy are ignored, and the run length is unchanged.
